// File: rtl/fir_pkg.sv
// Shared types and width helpers for the serial symmetric FIR.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_TAPS = 32;
  localparam int DEF_DW   = 16;
  localparam int DEF_CW   = 20;
  localparam int DEF_FRAC = 16;

  // Accumulator sized so a full TAPS/2 sum of worst-case products cannot overflow.
  function automatic int acc_width(input int dw, input int cw, input int taps);
    return dw + 1 + cw + $clog2(taps / 2);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Pre-add / multiply / accumulate datapath for one coefficient pair per cycle.
module fir_mac #(
  parameter int DW   = 16,
  parameter int CW   = 20,
  parameter int ACCW = 41
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic signed [DW-1:0]   xa_i,
  input  logic signed [DW-1:0]   xb_i,
  input  logic signed [CW-1:0]   c_i,
  output logic signed [ACCW-1:0] acc_nx_o
);

  localparam int PW = DW + 1 + CW;

  logic signed [DW:0]     pre;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc_q, acc_d;

  assign pre  = (DW+1)'(xa_i) + (DW+1)'(xb_i);
  assign prod = PW'(pre) * PW'(c_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q + ACCW'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  // Exposing the next value lets the top register the rounded result on the last MAC edge.
  assign acc_nx_o = acc_d;

endmodule

// File: rtl/fir_sym_serial.sv
// Serial symmetric FIR: FSM, delay line and coefficient RAM around fir_mac.
// Optional FIR_SAT_EN clamps the rounded output instead of wrapping it.
//
// state | meaning
// IDLE  | ready for a sample; coefficient writes honoured
// MAC   | one pair k per cycle, k = 0 .. TAPS/2-1
// OUT   | result visible, fir_valid pulses if the delay line is warm
module fir_sym_serial
  import fir_pkg::*;
#(
  parameter int TAPS = DEF_TAPS,
  parameter int DW   = DEF_DW,
  parameter int CW   = DEF_CW,
  parameter int FRAC = DEF_FRAC
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic signed [DW-1:0]        data,
  input  logic                        coef_we,
  input  logic [$clog2(TAPS/2)-1:0]   coef_addr,
  input  logic signed [CW-1:0]        coef_wdata,
  output logic                        fir_valid,
  output logic signed [DW-1:0]        fir_d
);

  localparam int NP   = TAPS / 2;
  localparam int KW   = $clog2(NP);
  localparam int XW   = $clog2(TAPS);
  localparam int WW   = XW + 1;
  localparam int ACCW = acc_width(DW, CW, TAPS);
  localparam logic [KW:0] NP_V = (KW+1)'(NP);

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [WW-1:0]          warm_q, warm_d;
  logic signed [DW-1:0]   fir_d_q, fir_d_d;
  logic                   fir_valid_q, fir_valid_d;
  logic signed [DW-1:0]   x_q [TAPS];
  logic signed [CW-1:0]   c_q [NP];

  logic                   accept, mac_en, last, done;
  logic [XW-1:0]          idx_lo, idx_hi;
  logic signed [ACCW-1:0] acc_nx, rnd_sum;
  logic signed [DW-1:0]   rnd_out;

  assign idx_lo = {1'b0, k_q};
  assign idx_hi = XW'(TAPS - 1) - idx_lo;
  assign last   = (k_q == KW'(NP - 1));

  always_comb begin
    state_d    = state_q;
    data_ready = 1'b0;
    accept     = 1'b0;
    mac_en     = 1'b0;
    case (state_q)
      IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          accept  = 1'b1;
          state_d = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last) state_d = OUT;
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  fir_mac #(
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept),
    .en_i     (mac_en),
    .xa_i     (x_q[idx_lo]),
    .xb_i     (x_q[idx_hi]),
    .c_i      (c_q[k_q]),
    .acc_nx_o (acc_nx)
  );

  assign rnd_sum = acc_nx + (ACCW'(1) << (FRAC - 1));

`ifdef FIR_SAT_EN
  logic signed [ACCW-1:0] rnd_sh;
  logic [ACCW-DW:0]       rnd_hi;
  assign rnd_sh = rnd_sum >>> FRAC;
  assign rnd_hi = rnd_sh[ACCW-1:DW-1];
  always_comb begin
    rnd_out = rnd_sh[DW-1:0];
    if (!(&rnd_hi) && (|rnd_hi))
      rnd_out = rnd_hi[ACCW-DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end
`else
  assign rnd_out = DW'(rnd_sum >>> FRAC);
`endif

  // The result is registered on the final MAC edge so fir_d and fir_valid line up in OUT.
  assign done = mac_en && last;

  always_comb begin
    k_d = k_q;
    if (accept)      k_d = '0;
    else if (mac_en) k_d = k_q + KW'(1);
    warm_d = warm_q;
    if (accept && (warm_q != WW'(TAPS))) warm_d = warm_q + WW'(1);
    fir_valid_d = done && (warm_q == WW'(TAPS));
    fir_d_d     = done ? rnd_out : fir_d_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      warm_q      <= '0;
      fir_d_q     <= '0;
      fir_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      warm_q      <= warm_d;
      fir_d_q     <= fir_d_d;
      fir_valid_q <= fir_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
    end else if (accept) begin
      x_q[0] <= data;
      for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) c_q[i] <= '0;
    end else if (coef_we && (state_q == IDLE) && ({1'b0, coef_addr} < NP_V)) begin
      c_q[coef_addr] <= coef_wdata;
    end
  end

  assign fir_valid = fir_valid_q;
  assign fir_d     = fir_d_q;

endmodule

// File: tb/tb_fir_sym_serial.sv
// Directed table-driven bench for fir_sym_serial (TAPS=32, DW=16, CW=20, FRAC=16).
module tb_fir_sym_serial;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               data_valid;
  logic               data_ready;
  logic signed [15:0] data;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [19:0] coef_wdata;
  logic               fir_valid;
  logic signed [15:0] fir_d;

  always #5 clk = ~clk;

  fir_sym_serial #(.TAPS(32), .DW(16), .CW(20), .FRAC(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .data       (data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d)
  );

  // kind: 0 = sample, 1 = coefficient write only, 2 = sample with coefficient write
  typedef struct {
    int                 kind;
    logic [3:0]         ca;
    logic signed [19:0] cd;
    logic signed [15:0] din;
    bit                 ev;
    bit                 cv;
    logic signed [15:0] ed;
  } vec_t;

  vec_t tab[$];
  int   n_chk  = 0;
  int   n_pass = 0;

`ifdef FIR_SAT_EN
  localparam int EXP_POS = 32767;
  localparam int EXP_NEG = -32768;
`else
  localparam int EXP_POS = -5536;
  localparam int EXP_NEG = 5536;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic add_s(input int kind, input logic [3:0] ca, input logic signed [19:0] cd,
                       input logic signed [15:0] din, input bit ev, input bit cv,
                       input logic signed [15:0] ed);
    vec_t v;
    v.kind = kind; v.ca = ca; v.cd = cd; v.din = din; v.ev = ev; v.cv = cv; v.ed = ed;
    tab.push_back(v);
  endtask

  task automatic add_c(input logic [3:0] ca, input logic signed [19:0] cd);
    add_s(1, ca, cd, 16'sd0, 1'b0, 1'b0, 16'sd0);
  endtask

  task automatic wait_ready(input string nm);
    int n = 0;
    while (!data_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!data_ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic send(input logic signed [15:0] s, input bit cw, input logic [3:0] ca,
                      input logic signed [19:0] cd, output bit gv,
                      output logic signed [15:0] gd, output int lat, output bit tmo);
    data = s; data_valid = 1'b1;
    coef_we = cw; coef_addr = ca; coef_wdata = cd;
    @(posedge clk); #1;
    data_valid = 1'b0; coef_we = 1'b0;
    gv = 1'b0; gd = 16'sd0; lat = 0; tmo = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (fir_valid) begin gv = 1'b1; gd = fir_d; lat = i; end
      if (data_ready) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic run_tab(input string phase);
    bit gv, tmo;
    logic signed [15:0] gd;
    int lat;
    for (int i = 0; i < tab.size(); i++) begin
      if (tab[i].kind == 1) begin
        coef_we = 1'b1; coef_addr = tab[i].ca; coef_wdata = tab[i].cd;
        @(posedge clk); #1;
        coef_we = 1'b0;
      end else begin
        send(tab[i].din, tab[i].kind == 2, tab[i].ca, tab[i].cd, gv, gd, lat, tmo);
        if (tmo) chk($sformatf("%s[%0d]_timeout", phase, i), 1, 0);
        chk($sformatf("%s[%0d]_valid", phase, i), int'(gv), int'(tab[i].ev));
        if (tab[i].ev) chk($sformatf("%s[%0d]_latency", phase, i), lat, 16);
        if (tab[i].cv) chk($sformatf("%s[%0d]_fir_d", phase, i), int'(gd), int'(tab[i].ed));
      end
    end
    tab.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int last_acc, low, pulses, cnt;
    rst_n = 1'b0; data_valid = 1'b0; data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_ready", int'(data_ready), 1);
    chk("rst_fir_valid", int'(fir_valid), 0);
    chk("rst_fir_d", int'(fir_d), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse through c[0] only: output is x[0] + x[31]
    add_c(4'd0, 20'sd65536);
    for (int i = 0; i < 31; i++) add_s(0, 0, 0, 16'sd0, 1'b0, 1'b0, 16'sd0);
    add_s(0, 0, 0, 16'sd100, 1'b1, 1'b1, 16'sd100);
    for (int i = 0; i < 30; i++) add_s(0, 0, 0, 16'sd0, 1'b1, 1'b1, 16'sd0);
    add_s(0, 0, 0, 16'sd0, 1'b1, 1'b1, 16'sd100);
    add_s(0, 0, 0, 16'sd0, 1'b1, 1'b1, 16'sd0);
    run_tab("impulse");

    add_c(4'd0, 20'sd32768);
    add_s(0, 0, 0, 16'sd3, 1'b1, 1'b1, 16'sd2);
    add_s(0, 0, 0, -16'sd3, 1'b1, 1'b1, -16'sd1);
    run_tab("round");

    // Coefficient written in the accepting cycle must apply to that sample
    add_s(2, 4'd0, 20'sd131072, 16'sd30000, 1'b1, 1'b1, 16'(EXP_POS));
    add_s(0, 0, 0, -16'sd30000, 1'b1, 1'b1, 16'(EXP_NEG));
    run_tab("ovf");

    for (int k = 0; k < 16; k++) add_c(4'(k), 20'sd2048);
    for (int i = 0; i < 31; i++) add_s(0, 0, 0, 16'sd1000, 1'b1, 1'b0, 16'sd0);
    add_s(0, 0, 0, 16'sd1000, 1'b1, 1'b1, 16'sd1000);
    add_s(0, 0, 0, 16'sd1000, 1'b1, 1'b1, 16'sd1000);
    run_tab("dc");

    // Back-to-back handshake with a coefficient write dropped during MAC
    data = 16'sd1000; data_valid = 1'b1;
    last_acc = -1; low = 0; pulses = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (data_ready) begin
        if (low > 0) chk("hs_ready_low_run", low, 17);
        low = 0;
        if (last_acc >= 0) chk("hs_accept_period", cyc - last_acc, 18);
        last_acc = cyc;
      end else begin
        low++;
      end
      if (fir_valid) begin
        pulses++;
        chk("hs_fir_d", int'(fir_d), 1000);
      end
      coef_we = (cyc == 20); coef_addr = 4'd0; coef_wdata = 20'sd0;
      @(posedge clk); #1;
    end
    data_valid = 1'b0; coef_we = 1'b0;
    chk("hs_pulse_count", pulses, 4);
    wait_ready("hs");

    // Reset in the middle of a MAC pass
    data = 16'sd5; data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #2;
    chk("midrst_data_ready", int'(data_ready), 1);
    chk("midrst_fir_valid", int'(fir_valid), 0);
    chk("midrst_fir_d", int'(fir_d), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (fir_valid) cnt++;
    end
    chk("postrst_no_valid", cnt, 0);

    add_c(4'd0, 20'sd65536);
    for (int i = 0; i < 31; i++) add_s(0, 0, 0, 16'sd7, 1'b0, 1'b0, 16'sd0);
    add_s(0, 0, 0, 16'sd7, 1'b1, 1'b1, 16'sd14);
    run_tab("reload");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
